// File: rtl/fifo_chk_pkg.sv
// Shared types and constants for the synchronous FIFO checker.
package fifo_chk_pkg;

    localparam int unsigned ERR_W = 8;

    // One value per err_vec bit, in bit order.
    typedef enum logic [2:0] {
        ErrData   = 3'd0,
        ErrAck    = 3'd1,
        ErrOvf    = 3'd2,
        ErrUdf    = 3'd3,
        ErrFull   = 3'd4,
        ErrEmpty  = 3'd5,
        ErrAfull  = 3'd6,
        ErrAempty = 3'd7
    } err_idx_e;

    typedef logic [ERR_W-1:0] err_vec_t;

    // Bits needed to hold an occupancy of 0..depth inclusive.
    function automatic int unsigned cnt_bits(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_chk_model.sv
// Shadow FIFO: tracks occupancy, pointers and memory of the FIFO under test
// and produces the values its outputs must show one cycle after each edge.
// Optional data tracking is built only when FIFO_CHK_DATA_EN is defined.
module fifo_chk_model
    import fifo_chk_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_wr_en,
    input  logic                  i_rd_en,
    input  logic [DATA_WIDTH-1:0] i_data_in,
    output logic [DATA_WIDTH-1:0] o_exp_dout,
    output logic                  o_exp_rd_vld,
    output logic                  o_exp_ack,
    output logic                  o_exp_ovf,
    output logic                  o_exp_udf,
    output logic                  o_exp_full,
    output logic                  o_exp_empty,
    output logic                  o_exp_afull,
    output logic                  o_exp_aempty
);

    localparam int unsigned   CW      = cnt_bits(FIFO_DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] AFULL_C = CW'(FIFO_DEPTH - 1);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    logic [CW-1:0] r_cnt;
    logic          r_ack;
    logic          r_ovf;
    logic          r_udf;
    logic          w_full_m;
    logic          w_empty_m;
    logic          w_wr_acc;
    logic          w_rd_acc;

    // Full/empty refuse the request; the other side of a simultaneous pair still goes.
    assign w_full_m  = (r_cnt == DEPTH_C);
    assign w_empty_m = (r_cnt == '0);
    assign w_wr_acc  = i_wr_en && !w_full_m;
    assign w_rd_acc  = i_rd_en && !w_empty_m;

    // Occupancy and expected registered handshake outputs.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
            r_ack <= 1'b0;
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            r_cnt <= r_cnt + CW'(w_wr_acc) - CW'(w_rd_acc);
            r_ack <= w_wr_acc;
            r_ovf <= i_wr_en && w_full_m;
            r_udf <= i_rd_en && w_empty_m;
        end
    end

    assign o_exp_ack    = r_ack;
    assign o_exp_ovf    = r_ovf;
    assign o_exp_udf    = r_udf;
    // Status flags follow the already-updated occupancy.
    assign o_exp_full   = w_full_m;
    assign o_exp_empty  = w_empty_m;
    assign o_exp_afull  = (r_cnt == AFULL_C);
    assign o_exp_aempty = (r_cnt == ONE_C);

`ifdef FIFO_CHK_DATA_EN
    localparam int unsigned PW = $clog2(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [DATA_WIDTH-1:0] r_dout;
    logic                  r_rd_vld;

    // Storage carries no reset; only locations that have been written are ever read.
    always_ff @(posedge i_clk) begin
        if (i_rst_n && w_wr_acc) begin
            r_mem[r_wr_ptr] <= i_data_in;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_dout   <= '0;
            r_rd_vld <= 1'b0;
        end else begin
            r_rd_vld <= w_rd_acc;
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
                r_dout   <= r_mem[r_rd_ptr];
            end
        end
    end

    assign o_exp_dout   = r_dout;
    assign o_exp_rd_vld = r_rd_vld;
`else
    logic w_unused_data;

    assign w_unused_data = ^i_data_in;
    assign o_exp_dout    = '0;
    assign o_exp_rd_vld  = 1'b0;
`endif

endmodule

// File: rtl/sync_fifo_checker.sv
// Hardware scoreboard for a synchronous FIFO: compares the snooped FIFO
// outputs against a shadow model and keeps error flags, counters and the
// first-error timestamp. Define FIFO_CHK_DATA_EN to also check data_out.
module sync_fifo_checker
    import fifo_chk_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_chk_en,
    input  logic                  i_wr_en,
    input  logic                  i_rd_en,
    input  logic [DATA_WIDTH-1:0] i_data_in,
    input  logic [DATA_WIDTH-1:0] i_data_out,
    input  logic                  i_wr_ack,
    input  logic                  i_overflow,
    input  logic                  i_underflow,
    input  logic                  i_full,
    input  logic                  i_almostfull,
    input  logic                  i_empty,
    input  logic                  i_almostempty,
    output err_vec_t              o_err_vec,
    output err_vec_t              o_err_sticky,
    output logic [CNT_WIDTH-1:0]  o_correct_count,
    output logic [CNT_WIDTH-1:0]  o_error_count,
    output logic                  o_first_err_valid,
    output logic [CNT_WIDTH-1:0]  o_first_err_cycle
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    logic [DATA_WIDTH-1:0] w_exp_dout;
    logic                  w_exp_rd_vld;
    logic                  w_exp_ack;
    logic                  w_exp_ovf;
    logic                  w_exp_udf;
    logic                  w_exp_full;
    logic                  w_exp_empty;
    logic                  w_exp_afull;
    logic                  w_exp_aempty;

    err_vec_t              w_err;
    err_vec_t              w_err_chk;
    logic                  w_checked;

    logic                  r_rst_n_prev;
    err_vec_t              r_err_vec;
    err_vec_t              r_err_sticky;
    logic [CNT_WIDTH-1:0]  r_correct;
    logic [CNT_WIDTH-1:0]  r_errors;
    logic [CNT_WIDTH-1:0]  r_cycle;
    logic                  r_first_valid;
    logic [CNT_WIDTH-1:0]  r_first_cycle;

    fifo_chk_model #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_model (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_wr_en      (i_wr_en),
        .i_rd_en      (i_rd_en),
        .i_data_in    (i_data_in),
        .o_exp_dout   (w_exp_dout),
        .o_exp_rd_vld (w_exp_rd_vld),
        .o_exp_ack    (w_exp_ack),
        .o_exp_ovf    (w_exp_ovf),
        .o_exp_udf    (w_exp_udf),
        .o_exp_full   (w_exp_full),
        .o_exp_empty  (w_exp_empty),
        .o_exp_afull  (w_exp_afull),
        .o_exp_aempty (w_exp_aempty)
    );

    // Field-by-field mismatch between the snooped FIFO outputs and the model.
    always_comb begin
        w_err = '0;
`ifdef FIFO_CHK_DATA_EN
        w_err[ErrData] = w_exp_rd_vld && (i_data_out != w_exp_dout);
`endif
        w_err[ErrAck]    = (i_wr_ack      != w_exp_ack);
        w_err[ErrOvf]    = (i_overflow    != w_exp_ovf);
        w_err[ErrUdf]    = (i_underflow   != w_exp_udf);
        w_err[ErrFull]   = (i_full        != w_exp_full);
        w_err[ErrEmpty]  = (i_empty       != w_exp_empty);
        w_err[ErrAfull]  = (i_almostfull  != w_exp_afull);
        w_err[ErrAempty] = (i_almostempty != w_exp_aempty);
    end

`ifndef FIFO_CHK_DATA_EN
    logic w_unused_data;

    assign w_unused_data = ^{i_data_out, w_exp_dout, w_exp_rd_vld};
`endif

    // Outputs left by a reset cycle are not meaningful, so skip the edge after one.
    assign w_checked = i_chk_en && r_rst_n_prev;
    assign w_err_chk = w_checked ? w_err : '0;

    // Verdict registers, saturating counters and first-error capture.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rst_n_prev  <= 1'b0;
            r_err_vec     <= '0;
            r_err_sticky  <= '0;
            r_correct     <= '0;
            r_errors      <= '0;
            r_cycle       <= '0;
            r_first_valid <= 1'b0;
            r_first_cycle <= '0;
        end else begin
            r_rst_n_prev <= 1'b1;
            r_err_vec    <= w_err_chk;
            r_err_sticky <= r_err_sticky | w_err_chk;
            if (r_cycle != CNT_MAX) begin
                r_cycle <= r_cycle + CNT_WIDTH'(1);
            end
            if (w_checked) begin
                if (w_err_chk == '0) begin
                    if (r_correct != CNT_MAX) begin
                        r_correct <= r_correct + CNT_WIDTH'(1);
                    end
                end else begin
                    if (r_errors != CNT_MAX) begin
                        r_errors <= r_errors + CNT_WIDTH'(1);
                    end
                    if (!r_first_valid) begin
                        r_first_valid <= 1'b1;
                        r_first_cycle <= r_cycle;
                    end
                end
            end
        end
    end

    assign o_err_vec         = r_err_vec;
    assign o_err_sticky      = r_err_sticky;
    assign o_correct_count   = r_correct;
    assign o_error_count     = r_errors;
    assign o_first_err_valid = r_first_valid;
    assign o_first_err_cycle = r_first_cycle;

endmodule

// File: tb/tb_sync_fifo_checker.sv
// Bench for sync_fifo_checker: emulates a correct FIFO with a queue, plants
// faults on chosen output fields, and predicts the checker verdict as the
// set of planted fields on every checked cycle.
module tb_sync_fifo_checker;

    localparam int DEPTH = 8;
`ifdef FIFO_CHK_DATA_EN
    localparam bit DATA_EN = 1'b1;
`else
    localparam bit DATA_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        chk_en;
    logic        wr_en;
    logic        rd_en;
    logic [15:0] din;
    logic [7:0]  inj;
    logic [15:0] inj_data;

    logic [7:0]  o_err_vec;
    logic [7:0]  o_err_sticky;
    logic [15:0] o_correct_count;
    logic [15:0] o_error_count;
    logic        o_first_err_valid;
    logic [15:0] o_first_err_cycle;

    // Emulated FIFO state
    logic [15:0] q [$];
    int          g_cnt;
    logic [15:0] g_dout;
    logic        g_ack;
    logic        g_ovf;
    logic        g_udf;
    logic        g_rdv;

    // Expected checker outputs
    logic        m_prev;
    logic [15:0] m_cyc;
    logic [7:0]  m_err;
    logic [7:0]  m_sticky;
    logic [15:0] m_cor;
    logic [15:0] m_ec;
    logic        m_fv;
    logic [15:0] m_fc;

    logic        b_wa;
    logic        b_ra;
    logic        b_chk;
    logic [7:0]  b_eff;

    int          n_pass;
    int          n_total;

    // Signals the FIFO under test presents, with planted faults
    logic [15:0] f_dout;
    logic        f_ack;
    logic        f_ovf;
    logic        f_udf;
    logic        f_full;
    logic        f_empty;
    logic        f_afull;
    logic        f_aempty;

    assign f_dout   = inj[0] ? inj_data : g_dout;
    assign f_ack    = g_ack ^ inj[1];
    assign f_ovf    = g_ovf ^ inj[2];
    assign f_udf    = g_udf ^ inj[3];
    assign f_full   = (g_cnt == DEPTH) ^ inj[4];
    assign f_empty  = (g_cnt == 0) ^ inj[5];
    assign f_afull  = (g_cnt == DEPTH - 1) ^ inj[6];
    assign f_aempty = (g_cnt == 1) ^ inj[7];

    sync_fifo_checker #(
        .DATA_WIDTH (16),
        .FIFO_DEPTH (DEPTH),
        .CNT_WIDTH  (16)
    ) dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_chk_en          (chk_en),
        .i_wr_en           (wr_en),
        .i_rd_en           (rd_en),
        .i_data_in         (din),
        .i_data_out        (f_dout),
        .i_wr_ack          (f_ack),
        .i_overflow        (f_ovf),
        .i_underflow       (f_udf),
        .i_full            (f_full),
        .i_almostfull      (f_afull),
        .i_empty           (f_empty),
        .i_almostempty     (f_aempty),
        .o_err_vec         (o_err_vec),
        .o_err_sticky      (o_err_sticky),
        .o_correct_count   (o_correct_count),
        .o_error_count     (o_error_count),
        .o_first_err_valid (o_first_err_valid),
        .o_first_err_cycle (o_first_err_cycle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A planted field is an error only on a checked cycle; data only after a real read.
    always_comb begin
        b_wa     = wr_en && (g_cnt != DEPTH);
        b_ra     = rd_en && (g_cnt != 0);
        b_chk    = chk_en && m_prev;
        b_eff    = inj;
        b_eff[0] = DATA_EN && inj[0] && g_rdv && (inj_data != g_dout);
        if (!b_chk) b_eff = 8'h00;
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            q.delete();
            g_cnt    <= 0;
            g_dout   <= 16'h0;
            g_ack    <= 1'b0;
            g_ovf    <= 1'b0;
            g_udf    <= 1'b0;
            g_rdv    <= 1'b0;
            m_prev   <= 1'b0;
            m_cyc    <= 16'h0;
            m_err    <= 8'h00;
            m_sticky <= 8'h00;
            m_cor    <= 16'h0;
            m_ec     <= 16'h0;
            m_fv     <= 1'b0;
            m_fc     <= 16'h0;
        end else begin
            m_prev   <= 1'b1;
            m_err    <= b_eff;
            m_sticky <= m_sticky | b_eff;
            if (m_cyc != 16'hFFFF) m_cyc <= m_cyc + 16'h1;
            if (b_chk && b_eff == 8'h00 && m_cor != 16'hFFFF) m_cor <= m_cor + 16'h1;
            if (b_chk && b_eff != 8'h00) begin
                if (m_ec != 16'hFFFF) m_ec <= m_ec + 16'h1;
                if (!m_fv) begin
                    m_fv <= 1'b1;
                    m_fc <= m_cyc;
                end
            end
            g_ack <= b_wa;
            g_ovf <= wr_en && (g_cnt == DEPTH);
            g_udf <= rd_en && (g_cnt == 0);
            g_rdv <= b_ra;
            g_cnt <= g_cnt + (b_wa ? 1 : 0) - (b_ra ? 1 : 0);
            if (b_ra) begin
                g_dout <= q[0];
                void'(q.pop_front());
            end
            if (b_wa) q.push_back(din);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Model comparison on every cycle, away from the active edge.
    always @(negedge clk) begin
        check("err_vec", {24'h0, o_err_vec}, {24'h0, m_err});
        check("err_sticky", {24'h0, o_err_sticky}, {24'h0, m_sticky});
        check("correct_count", {16'h0, o_correct_count}, {16'h0, m_cor});
        check("error_count", {16'h0, o_error_count}, {16'h0, m_ec});
        check("first_err_valid", {31'h0, o_first_err_valid}, {31'h0, m_fv});
        check("first_err_cycle", {16'h0, o_first_err_cycle}, {16'h0, m_fc});
    end

    task automatic step(input logic w, input logic r, input logic [15:0] d);
        wr_en = w;
        rd_en = r;
        din   = d;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected end of stimulus");
        $fatal(1, "watchdog");
    end

    initial begin
        n_pass   = 0;
        n_total  = 0;
        rst_n    = 1'b0;
        chk_en   = 1'b1;
        wr_en    = 1'b0;
        rd_en    = 1'b0;
        din      = 16'h0;
        inj      = 8'h00;
        inj_data = 16'h0;
        repeat (2) @(negedge clk);
        check("rst_err_vec", {24'h0, o_err_vec}, 32'h0);
        check("rst_correct", {16'h0, o_correct_count}, 32'h0);
        check("rst_first_valid", {31'h0, o_first_err_valid}, 32'h0);

        // Straight fill and drain
        rst_n = 1'b1;
        for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 16'(i));
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 16'h0);
        step(1'b0, 1'b0, 16'h0);
        check("burst_correct", {16'h0, o_correct_count}, 32'd16);
        check("burst_errors", {16'h0, o_error_count}, 32'd0);
        check("burst_last_dout", {16'h0, g_dout}, 32'h8);

        // Third read returns a corrupted word
        for (int i = 1; i <= 5; i++) step(1'b1, 1'b0, 16'(i));
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 16'h0);
        inj_data = 16'hDEAD;
        inj      = 8'h01;
        step(1'b0, 1'b0, 16'h0);
        check("dead_err_vec", {24'h0, o_err_vec}, DATA_EN ? 32'h1 : 32'h0);
        check("dead_sticky0", {31'h0, o_err_sticky[0]}, {31'h0, DATA_EN});
        check("dead_first_valid", {31'h0, o_first_err_valid}, {31'h0, DATA_EN});
        inj = 8'h00;
        for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 16'h0);

        // Ninth write overflows; the FIFO wrongly acknowledges it
        for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 16'h100 + 16'(i));
        step(1'b1, 1'b0, 16'h109);
        check("ovf_model", {31'h0, g_ovf}, 32'h1);
        inj = 8'h02;
        step(1'b0, 1'b0, 16'h0);
        check("ack_err_vec", {24'h0, o_err_vec}, 32'h2);
        check("ack_errors", {16'h0, o_error_count}, DATA_EN ? 32'd2 : 32'd1);
        check("first_err_cycle", {16'h0, o_first_err_cycle}, DATA_EN ? 32'd25 : 32'd37);
        inj = 8'h00;
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 16'h0);

        // Simultaneous requests at empty, then at full
        step(1'b1, 1'b1, 16'h55);
        check("empty_both_udf", {31'h0, g_udf}, 32'h1);
        check("empty_both_cnt", g_cnt, 32'd1);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 16'h200 + 16'(i));
        step(1'b1, 1'b1, 16'h2FF);
        check("full_both_ovf", {31'h0, g_ovf}, 32'h1);
        check("full_both_cnt", g_cnt, 32'd7);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 16'h0);

        // Reset in the middle of a burst at occupancy 5
        for (int i = 1; i <= 5; i++) step(1'b1, 1'b0, 16'h300 + 16'(i));
        rst_n = 1'b0;
        step(1'b1, 1'b0, 16'h306);
        check("midrst_correct", {16'h0, o_correct_count}, 32'd0);
        check("midrst_errors", {16'h0, o_error_count}, 32'd0);
        check("midrst_sticky", {24'h0, o_err_sticky}, 32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'h0);
        check("post_rst_correct", {16'h0, o_correct_count}, 32'd2);

        // Corruption while checking is disabled must leave no trace
        for (int i = 1; i <= 3; i++) step(1'b1, 1'b0, 16'h400 + 16'(i));
        check("pre_dis_correct", {16'h0, o_correct_count}, 32'd5);
        chk_en   = 1'b0;
        inj      = 8'hFF;
        inj_data = 16'hBEEF;
        step(1'b0, 1'b1, 16'h0);
        step(1'b0, 1'b1, 16'h0);
        step(1'b1, 1'b0, 16'h404);
        check("dis_correct", {16'h0, o_correct_count}, 32'd5);
        check("dis_errors", {16'h0, o_error_count}, 32'd0);
        check("dis_err_vec", {24'h0, o_err_vec}, 32'h0);
        chk_en = 1'b1;
        inj    = 8'h00;
        step(1'b0, 1'b1, 16'h0);
        step(1'b0, 1'b1, 16'h0);
        step(1'b0, 1'b0, 16'h0);
        check("reen_correct", {16'h0, o_correct_count}, 32'd8);
        check("reen_errors", {16'h0, o_error_count}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sync_fifo_checker.md
# sync_fifo_checker

Synthesizable, parametrised scoreboard for a synchronous FIFO. It sits beside the FIFO under test and snoops the same control, data and status wires. An internal shadow model predicts every registered output and status flag. Each checked cycle is compared field by field, and per-field error flags, sticky errors, saturating pass/fail counters and the first-error timestamp are exposed. It is the hardware successor to the bench-side monitor/scoreboard pair, usable in simulation, emulation and on FPGA.

## Interface
- DATA_WIDTH, 16, FIFO data width
- FIFO_DEPTH, 8, FIFO entries (≥4, power of two)
- CNT_WIDTH, 16, width of the correct/error/cycle counters
- clk  in  1  clock, shared with the FIFO under test
- rst_n  in  1  synchronous active-low reset, shared with the FIFO under test
- chk_en  in  1  comparison enable; the model tracks regardless
- wr_en, rd_en  in  1 each  FIFO requests
- data_in  in  DATA_WIDTH  FIFO write data
- data_out  in  DATA_WIDTH  FIFO read data
- wr_ack, overflow, underflow, full, almostfull, empty, almostempty  in  1 each  FIFO status
- err_vec  out  8  per-cycle mismatch, one bit per field
- err_sticky  out  8  OR-accumulated err_vec
- correct_count  out  CNT_WIDTH  clean checked cycles
- error_count  out  CNT_WIDTH  checked cycles with any mismatch
- first_err_valid  out  1  set when the first error is captured
- first_err_cycle  out  CNT_WIDTH  cycle_count value at the first error

## Operation
- Model state: occupancy cnt (0..FIFO_DEPTH), write and read pointers, shadow memory, expected registered outputs (exp_dout, exp_ack, exp_ovf, exp_udf).
- Write accepted: wr_en && !full_m, where full_m = (cnt == FIFO_DEPTH). Read accepted: rd_en && !empty_m, where empty_m = (cnt == 0).
- wr_en && rd_en at full: read only, overflow expected. At empty: write only, underflow expected. Otherwise both are accepted and cnt is unchanged.
- exp_ack = write accepted. exp_ovf = wr_en && full_m. exp_udf = rd_en && empty_m. On an accepted read, exp_dout = mem[rd_ptr].
- Expected flags come from the updated cnt:
  - full: cnt == FIFO_DEPTH
  - empty: cnt == 0
  - almostfull: cnt == FIFO_DEPTH-1
  - almostempty: cnt == 1
- Pointers wrap modulo FIFO_DEPTH. cnt never leaves 0..FIFO_DEPTH.
- err_vec bit order:
  - 0: data_out
  - 1: wr_ack
  - 2: overflow
  - 3: underflow
  - 4: full
  - 5: empty
  - 6: almostfull
  - 7: almostempty
- The data_out bit is compared only in the cycle after an accepted read. Otherwise it is forced to 0.
- A cycle is checked when chk_en is 1 and rst_n was 1 at the previous edge. Unchecked cycles give err_vec = 0 and leave the counters unchanged.
- correct_count increments on a checked cycle with err_vec == 0. error_count increments on a checked cycle with err_vec != 0. Both saturate at all-ones.
- cycle_count increments every cycle out of reset and saturates.
- The first checked cycle with err_vec != 0 loads first_err_cycle and sets first_err_valid. Both then hold until reset.

## Timing
- Reset: rst_n low at an edge clears all of the following:
  - model: cnt, pointers, exp_* registers
  - all counters
  - err_vec, err_sticky, first_err_valid, first_err_cycle
  - Expected state after reset: empty = 1, all other flags 0.
- Reset asserted mid-operation flushes the model. The cycle in which rst_n is low is never checked.
- Model update: at edge k, using wr_en, rd_en and data_in sampled at edge k, the same edge at which the FIFO registers them.
- Comparison: the FIFO outputs settled after edge k are sampled at edge k+1. err_vec, err_sticky and the counters become visible after edge k+1. Latency is one cycle from FIFO output to verdict.
- err_vec is a single-cycle pulse. err_sticky includes err_vec in the same cycle.

## Configuration
- FIFO_CHK_DATA_EN defined: shadow memory present and data_out compared.
- FIFO_CHK_DATA_EN undefined:
  - no shadow memory and no data pointers are instantiated
  - err_vec[0] and err_sticky[0] are tied to 0
  - only status and occupancy are checked

## Structure
- Package fifo_chk_pkg holds:
  - ERR_W = 8
  - err_idx_e enum, one value per err_vec bit in the order above
  - err_vec_t = logic [ERR_W-1:0]
- Sub-module fifo_chk_model: shadow FIFO holding cnt, pointers, memory and the exp_* registers. It outputs the expected values.
- sync_fifo_checker top: comparison, check qualification, counters and first-error capture.

## Test plan
All with DATA_WIDTH=16, FIFO_DEPTH=8:
- Reset, then 8 writes 0x0001..0x0008 and 8 reads.
  - data_out expected 0x0001..0x0008; error_count = 0; correct_count = number of checked cycles.
- Fill to 8, then a 9th write: overflow expected, wr_ack = 0. A FIFO that asserts wr_ack must set err_vec[1] one cycle later and error_count = 1.
- At empty, assert wr_en and rd_en together: underflow = 1, cnt becomes 1, almostempty = 1.
  - Repeat at full: overflow = 1, cnt stays 7 after the read, almostfull = 1.
- FIFO returns 0xDEAD instead of 0x0003:
  - err_vec = 8'h01 for one cycle
  - err_sticky[0] = 1
  - first_err_cycle = cycle_count of that check
- Assert rst_n mid-burst with cnt = 5. After release: no errors against empty = 1, and all counters are 0.
- chk_en = 0 while the FIFO is corrupted: counters frozen and err_vec = 0. The model still tracks, so no false errors appear after chk_en returns to 1.
